fetch_stage: RTL and testbench

- Instruction-fetch stage directly downstream of the program counter register.
- Takes the PC's current address, runs a ready-handshake with instruction memory, and loads the IF/ID pipeline register with instruction, PC and PC+4.
- Drives a one-cycle pc_advance pulse that tells the PC next-address path to load the next address.
- Absorbs decode back-pressure (stall) and branch redirects (flush) with a one-entry hold buffer.

---
 rtl/fetch_stage.sv | 156 +++++++++++++++
 tb/tb_fetch_stage.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage sitting after the PC register.
// Runs a ready handshake with instruction memory, fills the IF/ID register
// and pulses pc_advance when the PC may move on. A one-entry hold buffer
// absorbs a response that arrives while decode is stalled.
// Optional build macro: FETCH_TIMEOUT_EN adds a wait-cycle watchdog with a
// sticky fetch_err flag and an ERR state that only rst can leave.
//
//  state  | meaning
//  IDLE   | first cycle after reset, no request
//  WAIT   | request outstanding at pc_addr
//  HOLD   | response parked in the hold buffer until decode accepts it
//  ERR    | watchdog expired (FETCH_TIMEOUT_EN only), fetch halted
module fetch_stage #(
  parameter int XLEN           = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] pc_addr,
  output logic            pc_advance,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            imem_ready,
  input  logic            stall,
  input  logic            flush,
  output logic            if_id_valid,
  output logic [XLEN-1:0] if_id_instr,
  output logic [XLEN-1:0] if_id_pc,
  output logic [XLEN-1:0] if_id_pc_plus4,
  output logic            fetch_err
);

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("fetch_stage: TIMEOUT_CYCLES must be in 1..255");
  end

`ifdef FETCH_TIMEOUT_EN
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_HOLD, S_ERR} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_HOLD} state_t;
`endif

  state_t          state, next_state;
  logic            accept;
  logic            load_fetch, load_hold, unload_hold;
  logic            to_err, in_err, timeout_hit;
  logic [XLEN-1:0] hold_instr, hold_pc;

  assign accept    = !if_id_valid || !stall;
  assign imem_addr = pc_addr;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= next_state;
  end

  // Next state, handshake outputs and datapath strobes
  always_comb begin
    next_state  = state;
    imem_req    = 1'b0;
    pc_advance  = 1'b0;
    load_fetch  = 1'b0;
    load_hold   = 1'b0;
    unload_hold = 1'b0;
    to_err      = 1'b0;
    in_err      = 1'b0;
    case (state)
      S_IDLE: next_state = S_WAIT;
      S_WAIT: begin
        imem_req = 1'b1;
        if (flush) begin
          next_state = S_WAIT;
        end else if (imem_ready) begin
          pc_advance = 1'b1;
          if (accept) begin
            load_fetch = 1'b1;
          end else begin
            load_hold  = 1'b1;
            next_state = S_HOLD;
          end
        end else if (timeout_hit) begin
          to_err     = 1'b1;
`ifdef FETCH_TIMEOUT_EN
          next_state = S_ERR;
`endif
        end
      end
      S_HOLD: begin
        if (flush) begin
          next_state = S_WAIT;
        end else if (!stall) begin
          unload_hold = 1'b1;
          next_state  = S_WAIT;
        end
      end
`ifdef FETCH_TIMEOUT_EN
      S_ERR: in_err = 1'b1;
`endif
      default: next_state = S_IDLE;
    endcase
  end

  // IF/ID register and hold buffer; buffer occupancy is implied by HOLD
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      if_id_valid    <= 1'b0;
      if_id_instr    <= '0;
      if_id_pc       <= '0;
      if_id_pc_plus4 <= '0;
      hold_instr     <= '0;
      hold_pc        <= '0;
    end else if (flush && !in_err) begin
      if_id_valid <= 1'b0;
    end else if (load_fetch) begin
      if_id_valid    <= 1'b1;
      if_id_instr    <= imem_rdata;
      if_id_pc       <= pc_addr;
      if_id_pc_plus4 <= pc_addr + XLEN'(4);
    end else if (unload_hold) begin
      if_id_valid    <= 1'b1;
      if_id_instr    <= hold_instr;
      if_id_pc       <= hold_pc;
      if_id_pc_plus4 <= hold_pc + XLEN'(4);
    end else begin
      if (load_hold) begin
        hold_instr <= imem_rdata;
        hold_pc    <= pc_addr;
      end
      if (!stall || to_err || in_err) if_id_valid <= 1'b0;
    end
  end

`ifdef FETCH_TIMEOUT_EN
  logic [7:0] wait_cnt;

  assign timeout_hit = (wait_cnt == 8'(TIMEOUT_CYCLES - 1));

  // Count consecutive unanswered WAIT cycles; error flag is sticky until rst
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt  <= '0;
      fetch_err <= 1'b0;
    end else begin
      if (state == S_WAIT && !flush && !imem_ready) wait_cnt <= wait_cnt + 8'd1;
      else                                          wait_cnt <= '0;
      if (to_err) fetch_err <= 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign fetch_err   = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: reset, zero-wait stream, wait states,
// stall/hold, flush collisions, PC+4 wrap and (with FETCH_TIMEOUT_EN) timeout.
module tb_fetch_stage;
  localparam int XLEN = 32;

  logic            clk, rst;
  logic [XLEN-1:0] pc_addr, imem_addr, imem_rdata;
  logic            pc_advance, imem_req, imem_ready, stall, flush;
  logic            if_id_valid, fetch_err;
  logic [XLEN-1:0] if_id_instr, if_id_pc, if_id_pc_plus4;

  int total = 0;
  int bad   = 0;

  fetch_stage #(.XLEN(XLEN), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst(rst), .pc_addr(pc_addr), .pc_advance(pc_advance),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .imem_ready(imem_ready), .stall(stall), .flush(flush),
    .if_id_valid(if_id_valid), .if_id_instr(if_id_instr), .if_id_pc(if_id_pc),
    .if_id_pc_plus4(if_id_pc_plus4), .fetch_err(fetch_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; pc_addr = '0; imem_rdata = '0; imem_ready = 1'b0; stall = 1'b0; flush = 1'b0;
    tick(); tick();
    rst = 1'b0;
    total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL rst_idle_req got=%b want=0", imem_req); end
    tick();
    total++; if (imem_req !== 1'b1) begin bad++; $display("FAIL rst_first_req got=%b want=1", imem_req); end
    imem_ready = 1'b1; imem_rdata = 32'h11;
    tick();
    stall = 1'b1; imem_ready = 1'b0; pc_addr = 32'h4;
    tick();
    total++; if (if_id_valid !== 1'b1 || imem_req !== 1'b1) begin bad++; $display("FAIL rst_setup got=%b%b want=11", if_id_valid, imem_req); end
    rst = 1'b1;
    #1;
    total++;
    if ({if_id_valid, imem_req, pc_advance, fetch_err} !== 4'b0 || if_id_instr !== '0 || if_id_pc !== '0 || if_id_pc_plus4 !== '0) begin
      bad++; $display("FAIL rst_async got=%b%b%b%b %h %h %h want=0", if_id_valid, imem_req, pc_advance, fetch_err, if_id_instr, if_id_pc, if_id_pc_plus4);
    end
    tick(); tick();
    total++; if (if_id_valid !== 1'b0 || imem_req !== 1'b0) begin bad++; $display("FAIL rst_held got=%b%b want=00", if_id_valid, imem_req); end
    rst = 1'b0; stall = 1'b0; pc_addr = '0;
    #1;
    total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL rst_release_req got=%b want=0", imem_req); end
    tick();
    total++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin bad++; $display("FAIL rst_req_addr got=%b %h want=1 00000000", imem_req, imem_addr); end
  endtask

  task automatic test_stream();
    imem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      pc_addr = 32'(4 * i); imem_rdata = 32'hA0 + 32'(i);
      #1;
      total++; if (pc_advance !== 1'b1) begin bad++; $display("FAIL stream_adv%0d got=%b want=1", i, pc_advance); end
      tick();
      total++;
      if (if_id_valid !== 1'b1 || if_id_pc !== 32'(4 * i) || if_id_instr !== 32'hA0 + 32'(i) || if_id_pc_plus4 !== 32'(4 * i + 4)) begin
        bad++; $display("FAIL stream_entry%0d got=%b %h %h %h want=1 %h %h %h", i, if_id_valid, if_id_pc, if_id_instr, if_id_pc_plus4, 32'(4 * i), 32'hA0 + 32'(i), 32'(4 * i + 4));
      end
    end
    imem_ready = 1'b0; pc_addr = 32'hC;
    tick();
    total++; if (if_id_valid !== 1'b0 || if_id_instr !== 32'hA2) begin bad++; $display("FAIL stream_drain got=%b %h want=0 000000a2", if_id_valid, if_id_instr); end
  endtask

  task automatic test_wait_states();
    int pulses = 0;
    pc_addr = 32'h20; imem_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      if (c == 3) begin imem_ready = 1'b1; imem_rdata = 32'h55; end
      #1;
      if (pc_advance === 1'b1) pulses++;
      total++; if (imem_req !== 1'b1 || imem_addr !== 32'h20) begin bad++; $display("FAIL wait_addr%0d got=%b %h want=1 00000020", c, imem_req, imem_addr); end
      total++; if (pc_advance !== (c == 3)) begin bad++; $display("FAIL wait_adv%0d got=%b want=%b", c, pc_advance, c == 3); end
      tick();
    end
    imem_ready = 1'b0;
    total++; if (pulses != 1) begin bad++; $display("FAIL wait_pulses got=%0d want=1", pulses); end
    total++; if (if_id_valid !== 1'b1 || if_id_instr !== 32'h55 || if_id_pc !== 32'h20) begin bad++; $display("FAIL wait_entry got=%b %h %h want=1 00000055 00000020", if_id_valid, if_id_instr, if_id_pc); end
  endtask

  task automatic test_stall_hold();
    stall = 1'b1; pc_addr = 32'h10; imem_rdata = 32'hBEEF; imem_ready = 1'b1;
    #1;
    total++; if (pc_advance !== 1'b1) begin bad++; $display("FAIL hold_adv got=%b want=1", pc_advance); end
    tick();
    imem_ready = 1'b0; pc_addr = 32'h14;
    #1;
    total++; if (imem_req !== 1'b0 || pc_advance !== 1'b0) begin bad++; $display("FAIL hold_req got=%b%b want=00", imem_req, pc_advance); end
    total++; if (if_id_valid !== 1'b1 || if_id_instr !== 32'h55) begin bad++; $display("FAIL hold_keep got=%b %h want=1 00000055", if_id_valid, if_id_instr); end
    tick();
    total++; if (imem_req !== 1'b0 || if_id_instr !== 32'h55) begin bad++; $display("FAIL hold_stay got=%b %h want=0 00000055", imem_req, if_id_instr); end
    stall = 1'b0;
    tick();
    total++;
    if (if_id_valid !== 1'b1 || if_id_instr !== 32'hBEEF || if_id_pc !== 32'h10 || if_id_pc_plus4 !== 32'h14) begin
      bad++; $display("FAIL hold_release got=%b %h %h %h want=1 0000beef 00000010 00000014", if_id_valid, if_id_instr, if_id_pc, if_id_pc_plus4);
    end
    total++; if (imem_req !== 1'b1 || imem_addr !== 32'h14) begin bad++; $display("FAIL hold_resume got=%b %h want=1 00000014", imem_req, imem_addr); end
  endtask

  task automatic test_flush();
    flush = 1'b1; imem_ready = 1'b1; imem_rdata = 32'hDEAD; pc_addr = 32'h14; stall = 1'b0;
    #1;
    total++; if (pc_advance !== 1'b0) begin bad++; $display("FAIL flush_adv got=%b want=0", pc_advance); end
    tick();
    total++; if (if_id_valid !== 1'b0 || if_id_instr !== 32'hBEEF) begin bad++; $display("FAIL flush_drop got=%b %h want=0 0000beef", if_id_valid, if_id_instr); end
    flush = 1'b0; imem_ready = 1'b0;
    tick();
    total++; if (if_id_valid !== 1'b0 || imem_req !== 1'b1) begin bad++; $display("FAIL flush_after got=%b%b want=01", if_id_valid, imem_req); end
    // flush beats a coincident stall
    imem_ready = 1'b1; imem_rdata = 32'h77;
    tick();
    stall = 1'b1; flush = 1'b1; imem_ready = 1'b0;
    tick();
    total++; if (if_id_valid !== 1'b0 || imem_req !== 1'b1) begin bad++; $display("FAIL flush_stall got=%b%b want=01", if_id_valid, imem_req); end
    // flush in HOLD discards the parked response
    stall = 1'b0; flush = 1'b0; imem_ready = 1'b1; imem_rdata = 32'h88; pc_addr = 32'h18;
    tick();
    stall = 1'b1; imem_rdata = 32'h99; pc_addr = 32'h1C;
    tick();
    imem_ready = 1'b0; flush = 1'b1;
    tick();
    total++; if (imem_req !== 1'b1 || if_id_valid !== 1'b0) begin bad++; $display("FAIL flush_hold got=%b%b want=10", imem_req, if_id_valid); end
    flush = 1'b0; stall = 1'b0;
    tick();
    total++; if (if_id_valid !== 1'b0 || if_id_instr !== 32'h88) begin bad++; $display("FAIL flush_hold_empty got=%b %h want=0 00000088", if_id_valid, if_id_instr); end
  endtask

  task automatic test_wrap();
    pc_addr = 32'hFFFF_FFFC; imem_rdata = 32'h1234; imem_ready = 1'b1;
    tick();
    imem_ready = 1'b0;
    total++; if (if_id_pc !== 32'hFFFF_FFFC || if_id_pc_plus4 !== 32'h0) begin bad++; $display("FAIL wrap got=%h %h want=fffffffc 00000000", if_id_pc, if_id_pc_plus4); end
  endtask

  task automatic test_timeout();
    rst = 1'b1; imem_ready = 1'b0; stall = 1'b0; flush = 1'b0; pc_addr = 32'h40;
    tick();
    rst = 1'b0;
    tick();
`ifdef FETCH_TIMEOUT_EN
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (k == 7) begin
        total++; if (fetch_err !== 1'b0 || imem_req !== 1'b1) begin bad++; $display("FAIL to_early got=%b%b want=01", fetch_err, imem_req); end
      end
    end
    total++; if (fetch_err !== 1'b1 || imem_req !== 1'b0) begin bad++; $display("FAIL to_hit got=%b%b want=10", fetch_err, imem_req); end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    total++; if (fetch_err !== 1'b1 || imem_req !== 1'b0 || if_id_valid !== 1'b0) begin bad++; $display("FAIL to_flush got=%b%b%b want=100", fetch_err, imem_req, if_id_valid); end
    rst = 1'b1;
    #1;
    total++; if (fetch_err !== 1'b0) begin bad++; $display("FAIL to_rst got=%b want=0", fetch_err); end
    rst = 1'b0;
`else
    for (int k = 0; k < 20; k++) tick();
    total++; if (fetch_err !== 1'b0 || imem_req !== 1'b1) begin bad++; $display("FAIL no_timeout got=%b%b want=01", fetch_err, imem_req); end
`endif
  endtask

  initial begin
    test_reset();
    test_stream();
    test_wait_states();
    test_stall_hold();
    test_flush();
    test_wrap();
    test_timeout();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
